// File: rtl/calltrace_pkg.sv
// Shared constants and payload types for the multi-stack call-trace monitor.
package calltrace_pkg;

  localparam int unsigned MAX_STACKS = 64;

  // Control-word command bit indices (data_in[7:0])
  localparam int unsigned CMD_SELECT   = 0;
  localparam int unsigned CMD_CLEAR    = 1;
  localparam int unsigned CMD_FREEZE   = 2;
  localparam int unsigned CMD_UNFREEZE = 3;
  localparam int unsigned CMD_CLR_OVF  = 4;

  // Status word field offsets
  localparam int unsigned STS_EMPTY  = 0;
  localparam int unsigned STS_FULL   = 1;
  localparam int unsigned STS_FROZEN = 2;
  localparam int unsigned STS_COUNT  = 8;
  localparam int unsigned STS_MAX    = 16;
  localparam int unsigned STS_OVF    = 25;
  localparam int unsigned STS_SEL    = 26;

  localparam logic [31:0] DEFAULT_PUSH_IR = 32'hAFE0_0000;
  localparam logic [31:0] DEFAULT_POP_IR  = 32'hC700_000F;

  typedef struct packed {
    logic       ovf;
    logic [7:0] max_count;
    logic [7:0] count;
    logic       frozen;
    logic       full;
    logic       empty;
  } stack_stat_t;

  typedef struct packed {
    logic [5:0] sel;
    logic       ovf;
    logic       rsvd1;
    logic [7:0] max_count;
    logic [7:0] count;
    logic [4:0] rsvd0;
    logic       frozen;
    logic       full;
    logic       empty;
  } status_t;

  // Modular index of (base + off) within a ring of n slots, for base, off < n.
  function automatic int unsigned wrap_idx(input int unsigned base,
                                           input int unsigned off,
                                           input int unsigned n);
    int unsigned s;
    s = base + off;
    return (s >= n) ? s - n : s;
  endfunction

endpackage

// File: rtl/ct_stack.sv
// One trace stack: storage, count, high-water mark, overflow, freeze cursor.
// CALLTRACE_RING_EN builds a bottom pointer so pushes on full overwrite the oldest entry.
module ct_stack
  import calltrace_pkg::*;
#(
  parameter int unsigned NUM_SLOTS  = 32,
  parameter int unsigned DATA_WIDTH = 24
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  step,
  input  logic                  clear,
  input  logic                  freeze,
  input  logic                  unfreeze,
  input  logic                  clr_ovf,
  input  logic [DATA_WIDTH-1:0] push_data,
  output logic [DATA_WIDTH-1:0] rd_data_c,
  output logic [7:0]            count_c,
  output logic [7:0]            max_count_c,
  output logic                  ovf_c,
  output logic                  frozen_c,
  output logic                  full_c,
  output logic                  empty_c
);

  localparam int unsigned CW = $clog2(NUM_SLOTS + 1);
  localparam int unsigned IW = $clog2(NUM_SLOTS);

  logic [DATA_WIDTH-1:0] mem [NUM_SLOTS];
  logic [CW-1:0]         count_q, max_q, count_d, wr_off;
  logic [IW-1:0]         cursor_q, last_idx, base;
  logic                  ovf_q, frozen_q, ovf_set, wr_en;
  logic                  full, empty, act_push, act_pop;

`ifdef CALLTRACE_RING_EN
  logic [IW-1:0] bot_q;
  assign base = bot_q;
`else
  assign base = '0;
`endif

  // Logical offset (0 = oldest) to physical slot.
  function automatic logic [IW-1:0] phys(input logic [CW-1:0] off);
    return IW'(wrap_idx(32'(base), 32'(off), NUM_SLOTS));
  endfunction

  assign full     = (count_q == CW'(NUM_SLOTS));
  assign empty    = (count_q == '0);
  assign act_push = push && !frozen_q && !clear;
  assign act_pop  = pop && !frozen_q && !clear;
  assign last_idx = empty ? '0 : IW'(count_q - CW'(1));

  // Push/pop resolution; simultaneous push and pop replaces the top.
  always_comb begin
    wr_en   = 1'b0;
    wr_off  = count_q;
    count_d = count_q;
    ovf_set = 1'b0;
    if (act_push && act_pop && !empty) begin
      wr_en  = 1'b1;
      wr_off = count_q - CW'(1);
    end else if (act_push && !full) begin
      wr_en   = 1'b1;
      count_d = count_q + CW'(1);
    end else if (act_push) begin
      ovf_set = 1'b1;
`ifdef CALLTRACE_RING_EN
      wr_en  = 1'b1;
      wr_off = '0;
`endif
    end else if (act_pop && !empty) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[phys(wr_off)] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= '0;
      max_q    <= '0;
      ovf_q    <= 1'b0;
      frozen_q <= 1'b0;
      cursor_q <= '0;
    end else begin
      if (clear) begin
        count_q <= '0;
        max_q   <= '0;
        ovf_q   <= 1'b0;
      end else begin
        count_q <= count_d;
        if (count_d > max_q) max_q <= count_d;
        if (clr_ovf)      ovf_q <= 1'b0;
        else if (ovf_set) ovf_q <= 1'b1;
      end

      if (unfreeze)    frozen_q <= 1'b0;
      else if (freeze) frozen_q <= 1'b1;

      if (clear || unfreeze) cursor_q <= '0;
      else if (freeze)       cursor_q <= last_idx;
      else if (step && frozen_q)
        cursor_q <= (cursor_q == '0) ? last_idx : cursor_q - IW'(1);
    end
  end

`ifdef CALLTRACE_RING_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       bot_q <= '0;
    else if (clear)   bot_q <= '0;
    else if (ovf_set) bot_q <= (bot_q == IW'(NUM_SLOTS - 1)) ? '0 : bot_q + IW'(1);
  end
`endif

  always_comb begin
    rd_data_c = '0;
    if (!empty) rd_data_c = frozen_q ? mem[phys(CW'(cursor_q))] : mem[phys(count_q - CW'(1))];
  end

  assign count_c     = 8'(count_q);
  assign max_count_c = 8'(max_q);
  assign ovf_c       = ovf_q;
  assign frozen_c    = frozen_q;
  assign full_c      = full;
  assign empty_c     = empty;

endmodule

// File: rtl/calltrace_mp.sv
// Multi-stack call-trace monitor: IR-driven push/pop of LNK, bus access to stacks and status.
// Optional CALLTRACE_RING_EN makes full stacks overwrite their oldest entry.
module calltrace_mp
  import calltrace_pkg::*;
#(
  parameter int unsigned NUM_STACKS = 32,
  parameter int unsigned NUM_SLOTS  = 32,
  parameter int unsigned DATA_WIDTH = 24,
  parameter logic [31:0] PUSH_IR    = DEFAULT_PUSH_IR,
  parameter logic [31:0] POP_IR     = DEFAULT_POP_IR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stb,
  input  logic        we,
  input  logic        addr,
  input  logic [31:0] ir_in,
  input  logic [23:0] lnk_in,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        ack
);

  logic [5:0]            sel_q, tgt;
  logic [7:0]            cmd;
  logic                  push_seen_q, pop_seen_q, push_match, pop_match;
  logic                  ctl_wr, dat_wr, dat_rd, sts_rd, tgt_ok, sel_clr;
  logic                  hw_push, hw_pop, do_push, do_pop, sel_frozen;
  logic [DATA_WIDTH-1:0] push_data;
  logic [DATA_WIDTH-1:0] stk_rd [MAX_STACKS];
  stack_stat_t           stk_st [MAX_STACKS];
  status_t               sts;
  logic                  unused_bits;

  assign unused_bits = ^{data_in, lnk_in};
  assign ack         = stb;

  assign ctl_wr = stb && we && addr;
  assign dat_wr = stb && we && !addr;
  assign dat_rd = stb && !we && !addr;
  assign sts_rd = stb && !we && addr;
  assign cmd    = data_in[7:0];
  assign tgt    = data_in[13:8];
  assign tgt_ok = (32'(tgt) < NUM_STACKS);

  // A write that both selects and clears discards any concurrent hardware push.
  assign sel_clr = ctl_wr && tgt_ok && cmd[CMD_SELECT] && cmd[CMD_CLEAR];

  assign push_match = (ir_in == PUSH_IR);
  assign pop_match  = (ir_in == POP_IR);
  assign hw_push    = push_match && !push_seen_q;
  assign hw_pop     = pop_match && !pop_seen_q;

  assign sel_frozen = stk_st[sel_q].frozen;
  assign do_push    = dat_wr || (hw_push && !sel_clr);
  assign do_pop     = hw_pop || (dat_rd && !sel_frozen);
  assign push_data  = dat_wr ? data_in[DATA_WIDTH-1:0] : lnk_in[DATA_WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q       <= '0;
      push_seen_q <= 1'b0;
      pop_seen_q  <= 1'b0;
    end else begin
      push_seen_q <= push_match;
      pop_seen_q  <= pop_match;
      if (ctl_wr && tgt_ok && cmd[CMD_SELECT]) sel_q <= tgt;
    end
  end

  for (genvar i = 0; i < MAX_STACKS; i++) begin : g_stk
    if (i < NUM_STACKS) begin : g_on
      logic       hit, cmd_hit, s_ovf, s_frz, s_full, s_empty;
      logic [7:0] s_cnt, s_max;

      assign hit     = (sel_q == 6'(i));
      assign cmd_hit = ctl_wr && (tgt == 6'(i));

      ct_stack #(
        .NUM_SLOTS  (NUM_SLOTS),
        .DATA_WIDTH (DATA_WIDTH)
      ) u_stack (
        .clk         (clk),
        .rst_n       (rst_n),
        .push        (hit && do_push),
        .pop         (hit && do_pop),
        .step        (hit && dat_rd),
        .clear       (cmd_hit && cmd[CMD_CLEAR]),
        .freeze      (cmd_hit && cmd[CMD_FREEZE]),
        .unfreeze    (cmd_hit && cmd[CMD_UNFREEZE]),
        .clr_ovf     (cmd_hit && cmd[CMD_CLR_OVF]),
        .push_data   (push_data),
        .rd_data_c   (stk_rd[i]),
        .count_c     (s_cnt),
        .max_count_c (s_max),
        .ovf_c       (s_ovf),
        .frozen_c    (s_frz),
        .full_c      (s_full),
        .empty_c     (s_empty)
      );

      assign stk_st[i] = '{ovf: s_ovf, max_count: s_max, count: s_cnt,
                           frozen: s_frz, full: s_full, empty: s_empty};
    end else begin : g_off
      assign stk_rd[i] = '0;
      assign stk_st[i] = '0;
    end
  end

  // Read mux: data_out stays 0 unless a read strobe is present.
  always_comb begin
    sts           = '0;
    sts.sel       = sel_q;
    sts.ovf       = stk_st[sel_q].ovf;
    sts.max_count = stk_st[sel_q].max_count;
    sts.count     = stk_st[sel_q].count;
    sts.frozen    = stk_st[sel_q].frozen;
    sts.full      = stk_st[sel_q].full;
    sts.empty     = stk_st[sel_q].empty;
    data_out      = '0;
    if (dat_rd)      data_out = 32'(stk_rd[sel_q]);
    else if (sts_rd) data_out = sts;
  end

endmodule

// File: tb/tb_calltrace_mp.sv
// Scoreboard bench for calltrace_mp: directed bus/IR stimulus, reads checked by a monitor.
module tb_calltrace_mp;

  localparam logic [31:0] P_IR = 32'hAFE0_0000;
  localparam logic [31:0] Q_IR = 32'hC700_000F;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stb = 1'b0;
  logic        we = 1'b0;
  logic        addr = 1'b0;
  logic [31:0] ir_in = '0;
  logic [23:0] lnk_in = '0;
  logic [31:0] data_in = '0;
  logic [31:0] data_out;
  logic        ack;

  logic [31:0] exp_q[$];
  string       nm_q[$];
  int          n_chk = 0;
  int          n_pass = 0;
  logic        done_chk = 1'b0;
  logic        drained = 1'b0;
  logic [31:0] e;
  string       nm;

  calltrace_mp dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .stb      (stb),
    .we       (we),
    .addr     (addr),
    .ir_in    (ir_in),
    .lnk_in   (lnk_in),
    .data_in  (data_in),
    .data_out (data_out),
    .ack      (ack)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] sts(int sel, bit ovf, int mx, int cnt, bit frz, bit full, bit emp);
    return {6'(sel), ovf, 1'b0, 8'(mx), 8'(cnt), 5'b0, frz, full, emp};
  endfunction

  // Monitor: compares every read against the scoreboard, idle cycles against 0.
  always @(negedge clk) begin
    if (rst_n) begin
      if (stb && !we) begin
        n_chk++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_read: data_out=%h with no expected value queued", data_out);
        end else begin
          e  = exp_q.pop_front();
          nm = nm_q.pop_front();
          if (ack === 1'b1 && data_out === e) n_pass++;
          else $display("FAIL %s: got data_out=%h ack=%b, expected %h ack=1", nm, data_out, ack, e);
        end
      end else if (!stb) begin
        n_chk++;
        if (data_out === 32'h0 && ack === 1'b0) n_pass++;
        else $display("FAIL idle_out: got data_out=%h ack=%b, expected 0 ack=0", data_out, ack);
      end
      if (done_chk && !drained) begin
        drained = 1'b1;
        n_chk++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain: %0d expected reads never seen, expected 0", exp_q.size());
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus(input logic a, input logic w, input logic [31:0] d);
    stb = 1'b1; we = w; addr = a; data_in = d;
    @(posedge clk); #1;
    stb = 1'b0; we = 1'b0; data_in = '0;
  endtask

  task automatic ctl(input logic [31:0] d);
    bus(1'b1, 1'b1, d);
  endtask

  task automatic wr(input logic [31:0] d);
    bus(1'b0, 1'b1, d);
  endtask

  task automatic rd(input logic a, input logic [31:0] ev, input string name);
    exp_q.push_back(ev);
    nm_q.push_back(name);
    bus(a, 1'b0, '0);
  endtask

  task automatic ir_pulse(input logic [31:0] ir, input logic [23:0] lnk, input int n);
    ir_in = ir; lnk_in = lnk;
    repeat (n) @(posedge clk);
    #1;
    ir_in = '0;
    idle(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    idle(3);
    rst_n = 1'b1;
    idle(1);

    rd(1, sts(0, 0, 0, 0, 0, 0, 1), "reset_status");
    rd(0, 32'h0, "reset_empty_read");

    // Hardware pushes on stack 3
    ctl(32'h0301);
    rd(1, sts(3, 0, 0, 0, 0, 0, 1), "select3_status");
    ir_pulse(P_IR, 24'h000100, 1);
    ir_pulse(P_IR, 24'h000200, 1);
    rd(1, sts(3, 0, 2, 2, 0, 0, 0), "hw_push_status");
    rd(0, 32'h000200, "pop_first");
    rd(0, 32'h000100, "pop_second");
    rd(0, 32'h0, "pop_empty");
    rd(1, sts(3, 0, 2, 0, 0, 0, 1), "after_pops_status");

    // Held IR yields a single push
    ir_pulse(P_IR, 24'h000055, 5);
    rd(1, sts(3, 0, 2, 1, 0, 0, 0), "held_ir_status");
    rd(0, 32'h55, "held_ir_read");
    rd(0, 32'h0, "held_ir_empty");

    // Hardware pop
    wr(32'h11);
    wr(32'h22);
    ir_pulse(Q_IR, 24'h0, 1);
    rd(1, sts(3, 0, 2, 1, 0, 0, 0), "hw_pop_status");
    rd(0, 32'h11, "hw_pop_read");

    // Fill stack 0 past full
    ctl(32'h0001);
    for (int k = 0; k < 32; k++) wr(32'(k));
    rd(1, sts(0, 0, 32, 32, 0, 1, 0), "full_status");
    wr(32'h00AB_CDEF);
    rd(1, sts(0, 1, 32, 32, 0, 1, 0), "overflow_status");
`ifdef CALLTRACE_RING_EN
    rd(0, 32'h00AB_CDEF, "ring_top");
    for (int k = 31; k >= 1; k--) rd(0, 32'(k), "ring_drain");
`else
    for (int k = 31; k >= 0; k--) rd(0, 32'(k), "full_drain");
`endif
    rd(0, 32'h0, "drained_empty");
    rd(1, sts(0, 1, 32, 0, 0, 0, 1), "drained_status");
    ctl(32'h0010);
    rd(1, sts(0, 0, 32, 0, 0, 0, 1), "clr_ovf_status");

    // Freeze / cursor on stack 1
    ctl(32'h0101);
    wr(32'h1); wr(32'h2); wr(32'h3);
    ctl(32'h0104);
    ir_pulse(P_IR, 24'h000077, 1);
    wr(32'h99);
    rd(0, 32'h3, "frozen_rd0");
    rd(0, 32'h2, "frozen_rd1");
    rd(0, 32'h1, "frozen_rd2");
    rd(0, 32'h3, "frozen_wrap");
    rd(1, sts(1, 0, 3, 3, 1, 0, 0), "frozen_status");
    ctl(32'h0108);
    rd(0, 32'h3, "unfrozen_pop");
    rd(1, sts(1, 0, 3, 2, 0, 0, 0), "unfrozen_status");

    // Hardware push with concurrent bus pop replaces the top
    ir_in = P_IR; lnk_in = 24'h000044;
    rd(0, 32'h2, "pushpop_read");
    ir_in = '0;
    rd(0, 32'h44, "pushpop_top");
    rd(0, 32'h1, "pushpop_below");
    rd(0, 32'h0, "pushpop_empty");
    rd(1, sts(1, 0, 3, 0, 0, 0, 1), "pushpop_status");

    // Select+clear with concurrent hardware push
    ctl(32'h0201);
    wr(32'h5);
    ctl(32'h0401);
    ir_in = P_IR; lnk_in = 24'h000066;
    ctl(32'h0203);
    ir_in = '0;
    idle(1);
    rd(1, sts(2, 0, 0, 0, 0, 0, 1), "selclr_status");
    ctl(32'h0401);
    rd(1, sts(4, 0, 0, 0, 0, 0, 1), "selclr_push_dropped");
    ctl(32'h2001);
    rd(1, sts(4, 0, 0, 0, 0, 0, 1), "out_of_range_ignored");

    // Asynchronous reset in the middle of a write
    ctl(32'h0201);
    wr(32'h7);
    wr(32'h8);
    stb = 1'b1; we = 1'b1; addr = 1'b0; data_in = 32'h9;
    #3 rst_n = 1'b0;
    #3 stb = 1'b0; we = 1'b0; data_in = '0;
    idle(1);
    rst_n = 1'b1;
    idle(1);
    rd(1, sts(0, 0, 0, 0, 0, 0, 1), "post_reset_status");
    ctl(32'h0201);
    rd(1, sts(2, 0, 0, 0, 0, 0, 1), "post_reset_stack2");
    rd(0, 32'h0, "post_reset_read");

    done_chk = 1'b1;
    idle(3);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
